// File: rtl/systolic_psum_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_psum_addr_gen_pkg
// Description : Shared widths and FSM state encodings for the systolic
//               partial-sum address generator.
//               BIT_ADDR - psum SRAM address width
//               PE_COL   - number of PE columns (skew depth)
//               PASS_W   - accumulation pass count width
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_psum_addr_gen_pkg;

    localparam int BIT_ADDR = 8;
    localparam int PE_COL   = 4;
    localparam int PASS_W   = 8;
    localparam int DRAIN_W  = $clog2(PE_COL + 1);

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_INIT  = 3'd1;
    localparam logic [STATE_W-1:0] S_RUN   = 3'd2;
    localparam logic [STATE_W-1:0] S_DRAIN = 3'd3;
    localparam logic [STATE_W-1:0] S_WB    = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

endpackage : systolic_psum_addr_gen_pkg
`default_nettype wire

// File: rtl/psum_row_pass_counter.sv
`default_nettype none
// ============================================================================
// Module      : psum_row_pass_counter
// Description : Row counter that wraps at the row limit and advances a pass
//               counter on each wrap, with last-row / last-pass flags.
// Ports       : CLK, RSTn        - clock, async active-low reset
//               i_Clear          - synchronous clear (priority over step)
//               i_Step           - advance one row
//               i_Row_Limit      - rows per pass (N), must be non-zero when used
//               i_Pass_Limit     - passes (K), must be non-zero when used
//               o_Row            - current row index
//               o_Last_Row       - current row is N-1
//               o_Last_Pass      - current pass is K-1
// Revision    : 1.0 - initial release
// ============================================================================
module psum_row_pass_counter
    import systolic_psum_addr_gen_pkg::*;
(
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                i_Clear,
    input  logic                i_Step,
    input  logic [BIT_ADDR-1:0] i_Row_Limit,
    input  logic [PASS_W-1:0]   i_Pass_Limit,
    output logic [BIT_ADDR-1:0] o_Row,
    output logic                o_Last_Row,
    output logic                o_Last_Pass
);

    logic [BIT_ADDR-1:0] r_row;
    logic [PASS_W-1:0]   r_pass;

    assign o_Row       = r_row;
    assign o_Last_Row  = (r_row  == (i_Row_Limit  - BIT_ADDR'(1)));
    assign o_Last_Pass = (r_pass == (i_Pass_Limit - PASS_W'(1)));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_row  <= '0;
            r_pass <= '0;
        end else if (i_Clear) begin
            r_row  <= '0;
            r_pass <= '0;
        end else if (i_Step) begin
            if (o_Last_Row) begin
                r_row  <= '0;
                r_pass <= r_pass + PASS_W'(1);
            end else begin
                r_row  <= r_row + BIT_ADDR'(1);
            end
        end
    end

endmodule : psum_row_pass_counter
`default_nettype wire

// File: rtl/systolic_psum_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : systolic_psum_addr_gen
// Description : Partial-sum SRAM address generator for a systolic array tile:
//               optional init (zero-write) pass, K accumulation read passes,
//               a PE_COL-cycle drain for skewed column writes, then a final
//               write-back read pass.
// Config      : PSUM_INIT_EN - when defined, the INIT state writes each row
//               once before accumulation; when undefined, IDLE goes straight
//               to RUN and write enables stay 0.
// Ports       : CLK, RSTn          - clock, async active-low reset
//               i_Start            - one-cycle tile start (IDLE only)
//               i_Base_Addr        - first psum address of the tile
//               i_Num_Rows         - rows per pass (N); 0 finishes at once
//               i_Num_Pass         - passes (K); 0 treated as 1
//               o_Psram_Addr       - unskewed SRAM address
//               o_Psram_Addr_1buf  - RUN address delayed one cycle
//               o_Psram_Valid_1buf - RUN column-valid delayed one cycle
//               o_Psram_En/Wea     - per-column enable / write enable
//               o_Valid_WB_Psum    - final write-back phase
//               o_Busy, o_Done     - status
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_psum_addr_gen
    import systolic_psum_addr_gen_pkg::*;
(
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                i_Start,
    input  logic [BIT_ADDR-1:0] i_Base_Addr,
    input  logic [BIT_ADDR-1:0] i_Num_Rows,
    input  logic [PASS_W-1:0]   i_Num_Pass,
    output logic [BIT_ADDR-1:0] o_Psram_Addr,
    output logic [BIT_ADDR-1:0] o_Psram_Addr_1buf,
    output logic [PE_COL-1:0]   o_Psram_Valid_1buf,
    output logic [PE_COL-1:0]   o_Psram_En,
    output logic [PE_COL-1:0]   o_Psram_Wea,
    output logic                o_Valid_WB_Psum,
    output logic                o_Busy,
    output logic                o_Done
);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_next_state;
    logic [BIT_ADDR-1:0] r_base;
    logic [BIT_ADDR-1:0] r_rows;
    logic [PASS_W-1:0]   r_npass;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic [BIT_ADDR-1:0] w_row;
    logic                w_last_row;
    logic                w_last_pass;
    logic                w_step;
    logic                w_cnt_clear;
    logic                w_drain_last;
    logic [BIT_ADDR-1:0] w_addr;

    // Row counter restarts on every state change so each phase begins at row 0.
    assign w_step       = (r_state == S_INIT) || (r_state == S_RUN) || (r_state == S_WB);
    assign w_cnt_clear  = (r_state != w_next_state);
    assign w_drain_last = (r_drain_cnt == DRAIN_W'(PE_COL - 1));
    assign w_addr       = r_base + w_row;

    psum_row_pass_counter u_counter (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .i_Clear      (w_cnt_clear),
        .i_Step       (w_step),
        .i_Row_Limit  (r_rows),
        .i_Pass_Limit (r_npass),
        .o_Row        (w_row),
        .o_Last_Row   (w_last_row),
        .o_Last_Pass  (w_last_pass)
    );

    // State register and tile parameter latch
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_rows  <= '0;
            r_npass <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && i_Start) begin
                r_base  <= i_Base_Addr;
                r_rows  <= i_Num_Rows;
                r_npass <= (i_Num_Pass == '0) ? PASS_W'(1) : i_Num_Pass;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_Start) begin
                    if (i_Num_Rows == '0) begin
                        w_next_state = S_DONE;
                    end else begin
`ifdef PSUM_INIT_EN
                        w_next_state = S_INIT;
`else
                        w_next_state = S_RUN;
`endif
                    end
                end
            end
`ifdef PSUM_INIT_EN
            S_INIT:  if (w_last_row)                w_next_state = S_RUN;
`endif
            S_RUN:   if (w_last_row && w_last_pass) w_next_state = S_DRAIN;
            S_DRAIN: if (w_drain_last)              w_next_state = S_WB;
            S_WB:    if (w_last_row)                w_next_state = S_DONE;
            S_DONE:                                 w_next_state = S_IDLE;
            default:                                w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_Psram_Addr    = '0;
        o_Psram_En      = '0;
        o_Psram_Wea     = '0;
        o_Valid_WB_Psum = 1'b0;
        o_Busy          = (r_state != S_IDLE);
        o_Done          = (r_state == S_DONE);
        case (r_state)
`ifdef PSUM_INIT_EN
            S_INIT: begin
                o_Psram_Addr = w_addr;
                o_Psram_En   = '1;
                o_Psram_Wea  = '1;
            end
`endif
            S_RUN: begin
                o_Psram_Addr = w_addr;
                o_Psram_En   = '1;
            end
            S_WB: begin
                o_Psram_Addr    = w_addr;
                o_Psram_En      = '1;
                o_Valid_WB_Psum = 1'b1;
            end
            default: ;
        endcase
    end

    // Drain cycle counter and one-cycle-delayed RUN address/valid
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_drain_cnt        <= '0;
            o_Psram_Addr_1buf  <= '0;
            o_Psram_Valid_1buf <= '0;
        end else begin
            r_drain_cnt        <= (r_state == S_DRAIN) ? (r_drain_cnt + DRAIN_W'(1)) : '0;
            o_Psram_Addr_1buf  <= (r_state == S_RUN) ? w_addr : '0;
            o_Psram_Valid_1buf <= (r_state == S_RUN) ? {PE_COL{1'b1}} : '0;
        end
    end

endmodule : systolic_psum_addr_gen
`default_nettype wire

// File: tb/tb_systolic_psum_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_psum_addr_gen
// Description : Directed self-checking bench for systolic_psum_addr_gen.
//               Expected per-cycle outputs come from a phase model computed
//               from base/N/K (cycle 1 is the cycle after the Start edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_psum_addr_gen;
    import systolic_psum_addr_gen_pkg::*;

`ifdef PSUM_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic                CLK;
    logic                RSTn;
    logic                i_Start;
    logic [BIT_ADDR-1:0] i_Base_Addr;
    logic [BIT_ADDR-1:0] i_Num_Rows;
    logic [PASS_W-1:0]   i_Num_Pass;
    logic [BIT_ADDR-1:0] o_Psram_Addr;
    logic [BIT_ADDR-1:0] o_Psram_Addr_1buf;
    logic [PE_COL-1:0]   o_Psram_Valid_1buf;
    logic [PE_COL-1:0]   o_Psram_En;
    logic [PE_COL-1:0]   o_Psram_Wea;
    logic                o_Valid_WB_Psum;
    logic                o_Busy;
    logic                o_Done;

    int checks = 0;
    int errors = 0;

    systolic_psum_addr_gen u_dut (
        .CLK                (CLK),
        .RSTn               (RSTn),
        .i_Start            (i_Start),
        .i_Base_Addr        (i_Base_Addr),
        .i_Num_Rows         (i_Num_Rows),
        .i_Num_Pass         (i_Num_Pass),
        .o_Psram_Addr       (o_Psram_Addr),
        .o_Psram_Addr_1buf  (o_Psram_Addr_1buf),
        .o_Psram_Valid_1buf (o_Psram_Valid_1buf),
        .o_Psram_En         (o_Psram_En),
        .o_Psram_Wea        (o_Psram_Wea),
        .o_Valid_WB_Psum    (o_Valid_WB_Psum),
        .o_Busy             (o_Busy),
        .o_Done             (o_Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Phase model: outputs expected in cycle c of a tile started at edge 0.
    task automatic model(input int c, input logic [7:0] base, input int n, input int k,
                         output logic [7:0] addr, output logic [3:0] en, output logic [3:0] wea,
                         output logic vwb, output logic busy, output logic done,
                         output logic run);
        int kk, s_run, s_drain, s_wb, s_done;
        addr = 8'h00; en = 4'h0; wea = 4'h0; vwb = 1'b0; busy = 1'b0; done = 1'b0; run = 1'b0;
        if (c < 1) return;
        if (n == 0) begin
            if (c == 1) begin busy = 1'b1; done = 1'b1; end
            return;
        end
        kk      = (k == 0) ? 1 : k;
        s_run   = 1 + (INIT_EN ? n : 0);
        s_drain = s_run + kk * n;
        s_wb    = s_drain + 4;
        s_done  = s_wb + n;
        if (c < s_run) begin
            busy = 1'b1; addr = base + 8'(c - 1); en = 4'hF; wea = 4'hF;
        end else if (c < s_drain) begin
            busy = 1'b1; addr = base + 8'((c - s_run) % n); en = 4'hF; run = 1'b1;
        end else if (c < s_wb) begin
            busy = 1'b1;
        end else if (c < s_done) begin
            busy = 1'b1; addr = base + 8'(c - s_wb); en = 4'hF; vwb = 1'b1;
        end else if (c == s_done) begin
            busy = 1'b1; done = 1'b1;
        end
    endtask

    function automatic int last_cycle(input int n, input int k);
        int kk;
        if (n == 0) return 1;
        kk = (k == 0) ? 1 : k;
        return 1 + (INIT_EN ? n : 0) + kk * n + 4 + n;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".addr"},  32'(o_Psram_Addr),       32'h0);
        check({tag, ".addr1"}, 32'(o_Psram_Addr_1buf),  32'h0);
        check({tag, ".val1"},  32'(o_Psram_Valid_1buf), 32'h0);
        check({tag, ".en"},    32'(o_Psram_En),         32'h0);
        check({tag, ".wea"},   32'(o_Psram_Wea),        32'h0);
        check({tag, ".vwb"},   32'(o_Valid_WB_Psum),    32'h0);
        check({tag, ".busy"},  32'(o_Busy),             32'h0);
        check({tag, ".done"},  32'(o_Done),             32'h0);
    endtask

    // Runs one tile; ign_cyc > 0 pulses a stray Start in that cycle,
    // abort_cyc > 0 asserts reset mid-cycle in that cycle.
    task automatic run_tile(input string tag, input logic [7:0] base, input int n, input int k,
                            input int ign_cyc, input int abort_cyc);
        logic [7:0] e_addr, p_addr;
        logic [3:0] e_en, e_wea, p_en, p_wea;
        logic e_vwb, e_busy, e_done, e_run, p_vwb, p_busy, p_done, p_run;
        int total;
        total = last_cycle(n, k);
        @(negedge CLK);
        i_Base_Addr = base;
        i_Num_Rows  = 8'(n);
        i_Num_Pass  = 8'(k);
        i_Start     = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= total + 2; c++) begin
            @(negedge CLK);
            if (c == 1 || c == ign_cyc + 1) i_Start = 1'b0;
            model(c, base, n, k, e_addr, e_en, e_wea, e_vwb, e_busy, e_done, e_run);
            model(c - 1, base, n, k, p_addr, p_en, p_wea, p_vwb, p_busy, p_done, p_run);
            check({tag, ".addr"},  32'(o_Psram_Addr),       32'(e_addr));
            check({tag, ".en"},    32'(o_Psram_En),         32'(e_en));
            check({tag, ".wea"},   32'(o_Psram_Wea),        32'(e_wea));
            check({tag, ".vwb"},   32'(o_Valid_WB_Psum),    32'(e_vwb));
            check({tag, ".busy"},  32'(o_Busy),             32'(e_busy));
            check({tag, ".done"},  32'(o_Done),             32'(e_done));
            check({tag, ".addr1"}, 32'(o_Psram_Addr_1buf),  p_run ? 32'(p_addr) : 32'h0);
            check({tag, ".val1"},  32'(o_Psram_Valid_1buf), p_run ? 32'hF : 32'h0);
            if (c == ign_cyc) begin
                i_Start     = 1'b1;
                i_Base_Addr = 8'hA5;
                i_Num_Rows  = 8'd7;
            end
            if (c == abort_cyc) begin
                #2 RSTn = 1'b0;
                #1 check_all_zero({tag, ".rst"});
                repeat (3) begin
                    @(negedge CLK);
                    check_all_zero({tag, ".held"});
                end
                RSTn = 1'b1;
                repeat (2) begin
                    @(negedge CLK);
                    check_all_zero({tag, ".post"});
                end
                break;
            end
        end
    endtask

    initial begin
        RSTn        = 1'b0;
        i_Start     = 1'b0;
        i_Base_Addr = '0;
        i_Num_Rows  = '0;
        i_Num_Pass  = '0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RSTn = 1'b1;
        @(negedge CLK);
        check_all_zero("idle");

        run_tile("basic",   8'h10, 3, 2, 0, 0);
        run_tile("wrap",    8'hFF, 2, 1, 0, 0);
        run_tile("k0",      8'h20, 2, 0, 0, 0);
        run_tile("n0",      8'h30, 0, 3, 0, 0);
        run_tile("ignore",  8'h10, 3, 2, (INIT_EN ? 3 : 0) + 2, 0);
        run_tile("abort",   8'h10, 3, 2, 0, 6);
        run_tile("after",   8'h40, 1, 3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout @%0t: got hang expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_systolic_psum_addr_gen
`default_nettype wire

// File: doc/systolic_psum_addr_gen.md
SYSTOLIC_PSUM_ADDR_GEN -- requirements
Module: systolic_psum_addr_gen

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have RSTn  in  1  reset; asynchronous and active-low.
REQ-003 SHALL have i_Start  in  1  one-cycle tile start request.
REQ-004 SHALL have i_Base_Addr  in  BIT_ADDR  first psum SRAM address of tile.
REQ-005 SHALL have i_Num_Rows  in  BIT_ADDR  psum rows per pass (N).
REQ-006 SHALL have i_Num_Pass  in  8  accumulation passes (K).
REQ-007 SHALL have o_Psram_Addr  out  BIT_ADDR  read/write address, unskewed, feeds downstream skew loader.
REQ-008 SHALL have o_Psram_Addr_1buf  out  BIT_ADDR  o_Psram_Addr delayed 1 cycle (systolic write-back address).
REQ-009 SHALL have o_Psram_Valid_1buf  out  PE_COL  per-column psum-valid, delayed 1 cycle from read.
REQ-010 SHALL have o_Psram_En  out  PE_COL  per-column SRAM enable.
REQ-011 SHALL have o_Psram_Wea  out  PE_COL  per-column SRAM write enable.
REQ-012 SHALL have o_Valid_WB_Psum  out  1  final write-back phase; downstream bypasses skew.
REQ-013 SHALL have o_Busy  out  1  high whenever state != IDLE.
REQ-014 SHALL have o_Done  out  1  one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, INIT, RUN, DRAIN, WB, DONE.
REQ-016 IDLE: i_Start=1 SHALL latch base/N/K and go to INIT (RUN if init compiled out); i_Start ignored in all other states.
REQ-017 N=0 SHALL go IDLE->DONE directly; K=0 SHALL be treated as K=1.
REQ-018 INIT: N cycles, addr=base+i, En=all-ones, Wea=all-ones; then RUN.
REQ-019 RUN: K*N cycles, addr=base+(i mod N), En=all-ones, Wea=0; row counter wraps to 0 and pass counter increments at end of each pass, no gap cycles.
REQ-020 o_Psram_Addr_1buf and o_Psram_Valid_1buf SHALL be registered copies of RUN addr and (RUN ? all-ones : 0), exactly 1-cycle latency.
REQ-021 DRAIN: exactly PE_COL cycles, En=0, Wea=0, so skewed column writes complete; then WB.
REQ-022 WB: N cycles, addr=base+i, En=all-ones, Wea=0, o_Valid_WB_Psum=1; then DONE.
REQ-023 DONE: o_Done=1 for one cycle, then IDLE; next i_Start accepted in IDLE the following cycle.
REQ-024 Address arithmetic SHALL be BIT_ADDR wide, wrapping modulo 2^BIT_ADDR.
REQ-025 Outside INIT/RUN/WB, o_Psram_Addr SHALL hold 0, En/Wea/Valid_WB SHALL be 0.

Reset
REQ-026 RSTn low SHALL immediately force IDLE and all outputs and counters to 0, including mid-operation; no completion pulse is produced for an aborted tile.

Configuration
REQ-027 Macro PSUM_INIT_EN defined: INIT state present per REQ-018.
REQ-028 PSUM_INIT_EN undefined: INIT state absent, IDLE->RUN directly, Wea constant 0.

Structure
REQ-029 BIT_ADDR, PE_COL and FSM state encodings SHALL live in shared param.v.
REQ-030 Row/pass counting SHALL be one sub-module, psum_row_pass_counter (row wrap, pass increment, last flags).

Verification
REQ-031 PE_COL=4, PSUM_INIT_EN, base=0x10, N=3, K=2, Start at edge 0 -> INIT cycles 1-3 addr 0x10-0x12 Wea=4'hF; RUN 4-9; DRAIN 10-13; WB 14-16 Valid_WB=1; o_Done cycle 17.
REQ-032 Same without PSUM_INIT_EN -> RUN cycles 1-6, Wea never set, o_Done cycle 14.
REQ-033 During RUN -> o_Psram_Addr_1buf equals o_Psram_Addr of previous cycle; Valid_1buf=4'hF cycles 5-10 (case REQ-031).
REQ-034 base=all-ones, N=2, K=1 -> RUN addresses all-ones then 0.
REQ-035 N=0 -> o_Done cycle 1, En never asserted; i_Start pulses during RUN -> ignored, single o_Done.
REQ-036 RSTn low at cycle 6 of REQ-031 -> all outputs 0 asynchronously, IDLE, no o_Done.
